// File: rtl/rpn_pkg.sv
// Shared opcode encodings, FSM states and sizing helpers for the RPN operand stack.
package rpn_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_DUP   = 3'd3;
    localparam logic [2:0] OP_SWAP  = 3'd4;
    localparam logic [2:0] OP_ADD   = 3'd5;
    localparam logic [2:0] OP_SUB   = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    // A single-entry RAM still needs a one-bit address.
    function automatic int unsigned addr_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Operand storage below TOS: one write port, one registered read port, no reset.
module stack_ram #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ENTRIES = 15,
    parameter int unsigned AW      = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [ENTRIES];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/rpn_stack_unit.sv
// RPN operand-stack engine: TOS register over a synchronous-read RAM, one opcode per handshake.
module rpn_stack_unit
    import rpn_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       CLOCK_50,
    input  logic                       RESET_N,
    input  logic                       op_valid,
    input  logic [2:0]                 op,
    input  logic [WIDTH-1:0]           din,
    output logic                       op_ready,
    output logic                       done,
    output logic [WIDTH-1:0]           tos,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       carry,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int unsigned DW = $clog2(DEPTH+1);
    localparam int unsigned AW = addr_bits(DEPTH-1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             done_q, done_d;

    logic             ram_we, ram_re;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    logic [DW-1:0]    depth_m1, depth_m2;
    logic             is_empty, is_full;

    stack_ram #(
        .WIDTH  (WIDTH),
        .ENTRIES(DEPTH-1),
        .AW     (AW)
    ) u_ram (
        .clk  (CLOCK_50),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(tos_q),
        .re   (ram_re),
        .raddr(ram_raddr),
        .rdata(ram_rdata)
    );

    assign depth_m1 = depth_q - DW'(1);
    assign depth_m2 = depth_q - DW'(2);
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DEPTH_MAX);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tos_d     = tos_q;
        depth_d   = depth_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        done_d    = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_re    = 1'b0;
        ram_raddr = '0;

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    done_d = 1'b1;
                    case (op)
                        OP_PUSH: begin
                            if (is_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                if (!is_empty) begin
                                    ram_we    = 1'b1;
                                    ram_waddr = AW'(depth_m1);
                                end
                                tos_d   = din;
                                depth_d = depth_q + DW'(1);
                            end
                        end
                        OP_DUP: begin
                            if (is_empty) begin
                                unf_d = 1'b1;
                            end else if (is_full) begin
                                ovf_d = 1'b1;
                            end else begin
                                ram_we    = 1'b1;
                                ram_waddr = AW'(depth_m1);
                                depth_d   = depth_q + DW'(1);
                            end
                        end
                        OP_CLEAR: begin
                            tos_d   = '0;
                            depth_d = '0;
                            carry_d = 1'b0;
                            ovf_d   = 1'b0;
                            unf_d   = 1'b0;
                        end
                        OP_POP, OP_SWAP, OP_ADD, OP_SUB: begin
                            if (depth_q < ((op == OP_POP) ? DW'(1) : DW'(2))) begin
                                unf_d = 1'b1;
                            end else begin
                                done_d  = 1'b0;
                                state_d = S_EXEC;
                                op_d    = op;
                                // A POP of the last entry has nothing below TOS to fetch.
                                if (depth_q >= DW'(2)) begin
                                    ram_re    = 1'b1;
                                    ram_raddr = AW'(depth_m2);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_EXEC: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                case (op_q)
                    OP_POP: begin
                        tos_d   = (depth_q == DW'(1)) ? '0 : ram_rdata;
                        depth_d = depth_m1;
                    end
                    OP_SWAP: begin
                        ram_we    = 1'b1;
                        ram_waddr = AW'(depth_m2);
                        tos_d     = ram_rdata;
                    end
                    OP_ADD: begin
                        {carry_d, tos_d} = {1'b0, ram_rdata} + {1'b0, tos_q};
                        depth_d          = depth_m1;
                    end
                    OP_SUB: begin
                        tos_d   = ram_rdata - tos_q;
                        carry_d = (ram_rdata < tos_q);
                        depth_d = depth_m1;
                    end
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            tos_q   <= '0;
            depth_q <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tos_q   <= tos_d;
            depth_q <= depth_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            done_q  <= done_d;
        end
    end

    assign op_ready = (state_q == S_IDLE);
    assign done     = done_q;
    assign tos      = tos_q;
    assign depth    = depth_q;
    assign empty    = is_empty;
    assign full     = is_full;
    assign carry    = carry_q;
    assign ovf_err  = ovf_q;
    assign unf_err  = unf_q;

endmodule

// File: tb/tb_rpn_stack_unit.sv
// Directed bench for rpn_stack_unit: queue-based stack model checked every cycle plus literal pins.
module tb_rpn_stack_unit;
    import rpn_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic [2:0] op = OP_NOP;
    logic [7:0] din = '0;
    logic       op_ready, done, empty, full, carry, ovf_err, unf_err;
    logic [7:0] tos;
    logic [2:0] depth;

    rpn_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .op_valid(op_valid), .op(op), .din(din),
        .op_ready(op_ready), .done(done), .tos(tos), .depth(depth), .empty(empty),
        .full(full), .carry(carry), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    logic [7:0] stk[$];
    logic m_carry = 1'b0, m_ovf = 1'b0, m_unf = 1'b0, m_ready = 1'b1, m_done = 1'b0;
    int n_vec = 0, n_err = 0;

    function automatic logic [7:0] m_tos();
        return (stk.size() > 0) ? stk[stk.size()-1] : 8'h00;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endfunction

    // Returns 1 when the op is accepted and needs the extra EXEC cycle.
    function automatic bit m_accept(input logic [2:0] o, input logic [7:0] d);
        int n = stk.size();
        case (o)
            OP_PUSH: if (n == DEPTH) m_ovf = 1'b1; else stk.push_back(d);
            OP_DUP: begin
                if (n == 0) m_unf = 1'b1;
                else if (n == DEPTH) m_ovf = 1'b1;
                else stk.push_back(stk[n-1]);
            end
            OP_CLEAR: begin
                stk.delete();
                m_carry = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            end
            OP_POP: if (n < 1) m_unf = 1'b1; else return 1'b1;
            OP_SWAP, OP_ADD, OP_SUB: if (n < 2) m_unf = 1'b1; else return 1'b1;
            default: ;
        endcase
        return 1'b0;
    endfunction

    function automatic void m_exec(input logic [2:0] o);
        logic [7:0] a, b;
        logic [8:0] s;
        if (o == OP_POP) begin
            void'(stk.pop_back());
            return;
        end
        a = stk.pop_back();
        b = stk.pop_back();
        case (o)
            OP_SWAP: begin stk.push_back(a); stk.push_back(b); end
            OP_ADD: begin s = 9'(b) + 9'(a); stk.push_back(s[7:0]); m_carry = s[8]; end
            default: begin stk.push_back(b - a); m_carry = (b < a); end
        endcase
    endfunction

    always @(negedge clk) begin
        chk("tos", 32'(tos), 32'(m_tos()));
        chk("depth", 32'(depth), 32'(stk.size()));
        chk("empty", 32'(empty), 32'(stk.size() == 0));
        chk("full", 32'(full), 32'(stk.size() == DEPTH));
        chk("carry", 32'(carry), 32'(m_carry));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
        chk("unf_err", 32'(unf_err), 32'(m_unf));
        chk("op_ready", 32'(op_ready), 32'(m_ready));
        chk("done", 32'(done), 32'(m_done));
    end

    // Called at posedge+2; returns at posedge+2 of the done cycle.
    task automatic do_op(input logic [2:0] o, input logic [7:0] d, input bit hold = 1'b0);
        bit two;
        op_valid = 1'b1; op = o; din = d;
        @(posedge clk); #1;
        m_done = 1'b0;
        two = m_accept(o, d);
        if (!two) m_done = 1'b1; else m_ready = 1'b0;
        #1;
        op_valid = 1'b0; op = 3'($urandom); din = 8'($urandom);
        if (two) begin
            if (hold) begin op_valid = 1'b1; op = OP_CLEAR; end
            @(posedge clk); #1;
            m_exec(o); m_ready = 1'b1; m_done = 1'b1;
            #1 op_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1 m_done = 1'b0; #1;
        end
    endtask

    task automatic reset_in_exec();
        bit two;
        op_valid = 1'b1; op = OP_ADD;
        @(posedge clk); #1;
        m_done = 1'b0;
        two = m_accept(OP_ADD, 8'h00);
        m_ready = two ? 1'b0 : 1'b1;
        #1 op_valid = 1'b0; rst_n = 1'b0;
        #1;
        stk.delete();
        m_carry = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_ready = 1'b1; m_done = 1'b0;
        chk("rst_async_ready", 32'(op_ready), 32'd1);
        chk("rst_async_depth", 32'(depth), 32'd0);
        chk("rst_async_tos", 32'(tos), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    initial begin
        #17 rst_n = 1'b1;
        chk("reset_tos", 32'(tos), 32'h0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_ready", 32'(op_ready), 32'd1);

        do_op(OP_PUSH, 8'h05); do_op(OP_PUSH, 8'h03); do_op(OP_ADD, 8'h00);
        chk("add_tos", 32'(tos), 32'h08); chk("add_depth", 32'(depth), 32'd1);
        chk("add_carry", 32'(carry), 32'd0); chk("add_done", 32'(done), 32'd1);
        do_op(OP_CLEAR, 8'h00);

        do_op(OP_PUSH, 8'hF0); do_op(OP_PUSH, 8'h20); do_op(OP_ADD, 8'h00);
        chk("addc_tos", 32'(tos), 32'h10); chk("addc_carry", 32'(carry), 32'd1);
        do_op(OP_PUSH, 8'h11); do_op(OP_SUB, 8'h00);
        chk("sub_tos", 32'(tos), 32'hFF); chk("sub_borrow", 32'(carry), 32'd1);
        do_op(OP_CLEAR, 8'h00);

        for (int i = 1; i <= 4; i++) do_op(OP_PUSH, 8'(i));
        chk("full_after4", 32'(full), 32'd1);
        do_op(OP_PUSH, 8'h05);
        chk("ovf_flag", 32'(ovf_err), 32'd1); chk("ovf_tos", 32'(tos), 32'h04);
        chk("ovf_depth", 32'(depth), 32'd4);
        do_op(OP_DUP, 8'h00);
        do_op(OP_CLEAR, 8'h00);
        chk("clr_depth", 32'(depth), 32'd0); chk("clr_ovf", 32'(ovf_err), 32'd0);

        do_op(OP_PUSH, 8'h0A); do_op(OP_PUSH, 8'h0B); do_op(OP_SWAP, 8'h00);
        chk("swap_tos", 32'(tos), 32'h0A);
        do_op(OP_POP, 8'h00);
        chk("pop1_tos", 32'(tos), 32'h0B); chk("pop1_depth", 32'(depth), 32'd1);
        do_op(OP_POP, 8'h00);
        chk("pop2_tos", 32'(tos), 32'h00); chk("pop2_empty", 32'(empty), 32'd1);
        do_op(OP_POP, 8'h00);
        chk("pop3_unf", 32'(unf_err), 32'd1); chk("pop3_done", 32'(done), 32'd1);

        do_op(OP_CLEAR, 8'h00); do_op(OP_PUSH, 8'h09); do_op(OP_ADD, 8'h00);
        chk("add1_unf", 32'(unf_err), 32'd1); chk("add1_tos", 32'(tos), 32'h09);
        chk("add1_done", 32'(done), 32'd1);
        do_op(OP_DUP, 8'h00); do_op(OP_PUSH, 8'h02);
        do_op(OP_POP, 8'h00, 1'b1);
        do_op(OP_SUB, 8'h00);
        chk("sub0_tos", 32'(tos), 32'h00); chk("sub0_carry", 32'(carry), 32'd0);
        chk("sub0_depth", 32'(depth), 32'd1);
        idle(2);

        do_op(OP_CLEAR, 8'h00); do_op(OP_DUP, 8'h00); do_op(OP_NOP, 8'h00);
        do_op(OP_PUSH, 8'h01); do_op(OP_PUSH, 8'hFF); do_op(OP_ADD, 8'h00);
        chk("wrap_tos", 32'(tos), 32'h00); chk("wrap_carry", 32'(carry), 32'd1);
        idle(1);

        do_op(OP_PUSH, 8'h01); do_op(OP_PUSH, 8'h02);
        reset_in_exec();
        do_op(OP_PUSH, 8'h07);
        chk("post_rst_tos", 32'(tos), 32'h07); chk("post_rst_depth", 32'(depth), 32'd1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rpn_stack_unit.md
# rpn_stack_unit

Parametrised operand-stack engine for the RPN calculator, replacing the bare stack-pointer register/mux pair. It holds a top-of-stack (TOS) register plus a synchronous-read stack RAM, and executes one stack/arithmetic opcode per handshake. It reports depth, full/empty, carry and overflow/underflow errors to the board-level top (switches and keys in, LEDs and HEX out).

## Interface
- WIDTH, 8: operand width in bits.
- DEPTH, 16: maximum entries, including TOS; must be ≥2.
- CLOCK_50  in  1  sole clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- op_valid  in  1  opcode present this cycle.
- op  in  3  opcode:
  - 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 ADD, 6 SUB, 7 CLEAR.
- din  in  WIDTH  operand for PUSH.
- op_ready  out  1  unit can accept an opcode.
- done  out  1  one-cycle pulse when an accepted opcode completes, including rejected ones.
- tos  out  WIDTH  current top of stack; 0 when empty.
- depth  out  $clog2(DEPTH+1)  number of entries.
- empty, full  out  1  depth==0, depth==DEPTH.
- carry  out  1  carry-out of last ADD, or borrow of last SUB.
- ovf_err, unf_err  out  1  sticky overflow / underflow flags.

## Operation
- Accept occurs when op_valid && op_ready.
- Storage model:
  - Entry depth-1 lives in the tos register.
  - Entries 0..depth-2 live in ram[0..depth-2].
- FSM states are IDLE and EXEC. op_ready = (state==IDLE).
- Single-cycle ops complete at the accept edge, stay in IDLE, and pulse done the next cycle:
  - PUSH: if full, set ovf_err and make no change. Else, if depth>0, write tos→ram[depth-1]; tos←din; depth+1.
  - DUP: if empty, set unf_err. If full, set ovf_err. Else write tos→ram[depth-1]; depth+1.
  - CLEAR: depth←0, tos←0, carry←0, ovf_err←0, unf_err←0.
  - NOP: no state change; done still pulses.
- Two-cycle ops (POP, SWAP, ADD, SUB):
  - Precondition: POP needs depth≥1; the others need depth≥2.
  - On precondition failure: set unf_err, make no change, complete as a single-cycle op.
  - Otherwise, at the accept edge: RAM read address ← depth-2, opcode latched, state→EXEC.
  - In EXEC, with rd = RAM data:
    - POP: tos←(depth==1 ? 0 : rd); depth-1.
    - SWAP: write tos→ram[depth-2]; tos←rd.
    - ADD: {carry,tos}←rd+tos; depth-1.
    - SUB: tos←rd-tos, carry←(rd<tos); depth-1.
    - All: state→IDLE.
- Arithmetic is unsigned, modulo 2^WIDTH. carry changes only on ADD/SUB/CLEAR.
- Error flags never clear except by CLEAR or reset. A failed op leaves tos, depth, carry untouched.
- op and din are sampled only at accept. Inputs while op_ready=0 are ignored.

## Timing
- Reset values, asynchronous: state IDLE, op_ready=1, done=0, tos=0, depth=0, empty=1, full=0, carry=0, ovf_err=0, unf_err=0.
- RAM contents are not reset; they are unreachable at depth 0.
- Latency from accept edge to done pulse:
  - PUSH/DUP/CLEAR/NOP/rejected op: done high the cycle after accept, with new tos/depth visible in that same cycle.
  - POP/SWAP/ADD/SUB: op_ready low one cycle (EXEC). done high the cycle after EXEC, with results visible then.
- Throughput: one op per cycle for single-cycle ops, one per two cycles otherwise.
- RAM: one write port, one synchronous read port, read-during-write to different addresses only. The design never reads and writes the same address in one cycle.
- RESET_N asserted mid-EXEC aborts the op. The stack is empty after release.

## Structure
- Shared package rpn_pkg:
  - Opcode localparams OP_NOP…OP_CLEAR.
  - FSM state encodings S_IDLE, S_EXEC.
- Sub-module stack_ram:
  - Parameters WIDTH and DEPTH-1 entries.
  - One registered-read port, one write port.
  - No reset.
- Arithmetic, FSM and pointer logic live in rpn_stack_unit. Expected size ~200 lines.

## Test plan
- Reset, then PUSH 0x05 and PUSH 0x03, then ADD → done 2 cycles after ADD accept, tos=0x08, depth=1, carry=0.
- PUSH 0xF0, PUSH 0x20, ADD → tos=0x10, carry=1. Then PUSH 0x11, SUB → tos=0xFF, carry=1 (borrow).
- DEPTH=4: five PUSHes 1..5 → full=1 after fourth; fifth sets ovf_err=1 with tos=4, depth=4 unchanged. Then CLEAR → depth=0, ovf_err=0.
- PUSH 0x0A, PUSH 0x0B, SWAP → tos=0x0A; POP → tos=0x0B, depth=1; POP → tos=0, empty=1; POP → unf_err=1, done still pulses.
- ADD on depth=1 → unf_err=1, done one cycle after accept, tos/depth unchanged. op_valid held high during EXEC of a prior POP → second op not accepted until op_ready=1.
- RESET_N pulsed low during EXEC of ADD → all outputs at reset values asynchronously; first PUSH 0x07 after release → tos=0x07, depth=1.
